biquad_power_monitor: RTL

Downstream consumer of the two-stage biquad filter chain. Takes the filtered 8-sample × 12-bit stream on `aclk`. Over a programmable window of clocks it integrates sample power (sum of squares), tracks the peak absolute sample and counts saturated samples. It emits one result per window with a single-cycle valid strobe, plus a threshold flag for trigger qualification.

---
 rtl/bq_mon_pkg.sv | 68 ++++++
 rtl/sumsq8.sv | 100 ++++++++++
 rtl/biquad_power_monitor.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bq_mon_pkg.sv
// ---------------------------------------------------------------------------
// bq_mon_pkg
//   Shared constants and helpers for the biquad filter chain, the power
//   monitor and the trigger logic.
//   - NSAMP / NBITS / WINBITS : stream geometry and window-length field width
//   - acc_bits / sat_bits     : widths of the window accumulators
//   - sq_bits / sum_bits      : widths of one square and of one word's sum
//   - sat_pos/sat_neg_pattern : bit patterns of the two saturation codes
//   - mon_state_e, word_tag_t : monitor FSM states and per-word pipeline tags
// ---------------------------------------------------------------------------
package bq_mon_pkg;

  localparam int NSAMP   = 8;
  localparam int NBITS   = 12;
  localparam int WINBITS = 16;

  // Worst case is every sample at -2^(NBITS-1) for 2^WINBITS words, which
  // is exactly 2^(2*NBITS-2+log2(NSAMP)+WINBITS); one more bit holds it.
  function automatic int acc_bits(input int nsamp, input int nbits, input int winbits);
    return 2 * nbits + $clog2(nsamp) + winbits - 1;
  endfunction

  // Every sample of every word saturated gives 2^(log2(NSAMP)+WINBITS).
  function automatic int sat_bits(input int nsamp, input int winbits);
    return $clog2(nsamp) + winbits + 1;
  endfunction

  // A square of an NBITS two's complement value peaks at 2^(2*NBITS-2).
  function automatic int sq_bits(input int nbits);
    return 2 * nbits - 1;
  endfunction

  function automatic int sum_bits(input int nsamp, input int nbits);
    return sq_bits(nbits) + $clog2(nsamp);
  endfunction

  function automatic int popcnt_bits(input int nsamp);
    return $clog2(nsamp) + 1;
  endfunction

  // Largest positive code, 2^(nbits-1)-1.
  function automatic logic [31:0] sat_pos_pattern(input int nbits);
    return (32'd1 << (nbits - 1)) - 32'd1;
  endfunction

  // Most negative code, -2^(nbits-1), seen as its raw bit pattern.
  function automatic logic [31:0] sat_neg_pattern(input int nbits);
    return 32'd1 << (nbits - 1);
  endfunction

  localparam int SQBITS  = sq_bits(NBITS);
  localparam int SUMBITS = sum_bits(NSAMP, NBITS);
  localparam int PCBITS  = popcnt_bits(NSAMP);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mon_state_e;

  // Travels alongside each word so the accumulator stage knows whether the
  // word belongs to a window and whether it opens or closes that window.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } word_tag_t;

endpackage

// File: rtl/sumsq8.sv
// ---------------------------------------------------------------------------
// sumsq8
//   Purely pipelined per-word reduction, no control. Two register stages:
//     stage A : per-sample square, absolute value and saturation flag
//     stage B : sum of squares, largest magnitude, count of saturated samples
//   Ports:
//     clk      in   clock
//     rst      in   asynchronous active-high reset
//     dat      in   NSAMP*NBITS  packed signed samples, sample k at [NBITS*k +: NBITS]
//     sum_sq   out  SUMBITS      sum of the squares of the word
//     peak     out  NBITS        max |sample| (unsigned, so |-2^(NBITS-1)| fits)
//     sat_cnt  out  PCBITS       number of samples at either saturation code
// ---------------------------------------------------------------------------
module sumsq8
  import bq_mon_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSAMP*NBITS-1:0]   dat,
  output logic [SUMBITS-1:0]       sum_sq,
  output logic [NBITS-1:0]         peak,
  output logic [PCBITS-1:0]        sat_cnt
);

  localparam logic [NBITS-1:0] SAT_POS = NBITS'(sat_pos_pattern(NBITS));
  localparam logic [NBITS-1:0] SAT_NEG = NBITS'(sat_neg_pattern(NBITS));

  logic [NBITS-1:0]  word   [NSAMP];
  logic [NBITS-1:0]  abs_d  [NSAMP];
  logic [SQBITS-1:0] sq_d   [NSAMP];
  logic [NSAMP-1:0]  sat_d;

  logic [NBITS-1:0]  abs_q  [NSAMP];
  logic [SQBITS-1:0] sq_q   [NSAMP];
  logic [NSAMP-1:0]  sat_q;

  logic [SUMBITS-1:0] sum_d;
  logic [NBITS-1:0]   peak_d;
  logic [PCBITS-1:0]  pc_d;

  // Per-sample work. The square is taken of the magnitude rather than of the
  // signed value: the result is identical, and the product then needs only
  // SQBITS bits, so nothing is computed that is later thrown away. Negating
  // -2^(NBITS-1) wraps to the same bit pattern, which read unsigned is the
  // correct magnitude 2^(NBITS-1).
  always_comb begin
    for (int k = 0; k < NSAMP; k++) begin
      word[k]  = dat[NBITS*k +: NBITS];
      abs_d[k] = word[k][NBITS-1] ? (~word[k] + NBITS'(1)) : word[k];
      sq_d[k]  = SQBITS'(abs_d[k]) * SQBITS'(abs_d[k]);
      sat_d[k] = (word[k] == SAT_POS) || (word[k] == SAT_NEG);
    end
  end

  // Stage A register: squares, magnitudes and saturation flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSAMP; k++) begin
        abs_q[k] <= '0;
        sq_q[k]  <= '0;
      end
      sat_q <= '0;
    end else begin
      for (int k = 0; k < NSAMP; k++) begin
        abs_q[k] <= abs_d[k];
        sq_q[k]  <= sq_d[k];
      end
      sat_q <= sat_d;
    end
  end

  // Word-level reductions. SUMBITS already carries the log2(NSAMP) growth
  // bits, so the sum of eight squares cannot wrap.
  always_comb begin
    sum_d  = '0;
    peak_d = '0;
    pc_d   = '0;
    for (int k = 0; k < NSAMP; k++) begin
      sum_d = sum_d + SUMBITS'(sq_q[k]);
      if (abs_q[k] > peak_d) begin
        peak_d = abs_q[k];
      end
      pc_d = pc_d + PCBITS'(sat_q[k]);
    end
  end

  // Stage B register: the three per-word results handed to the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_sq  <= '0;
      peak    <= '0;
      sat_cnt <= '0;
    end else begin
      sum_sq  <= sum_d;
      peak    <= peak_d;
      sat_cnt <= pc_d;
    end
  end

endmodule

// File: rtl/biquad_power_monitor.sv
// ---------------------------------------------------------------------------
// biquad_power_monitor
//   Integrates sample power, tracks the peak magnitude and counts saturated
//   samples over a programmable window of clocks, producing one result per
//   window with a one-cycle valid strobe and a power-above-threshold flag.
//   Ports:
//     aclk          in   clock
//     rst_i         in   asynchronous active-high reset
//     enable_i      in   run windows while high; low aborts a partial window
//     window_len_i  in   WINBITS  window length minus one, latched at window start
//     thresh_i      in   ACCBITS  unsigned power threshold, latched at window start
//     dat_i         in   NSAMP*NBITS  samples, k=0 oldest at [NBITS*k +: NBITS]
//     pwr_o         out  ACCBITS  window sum of squares
//     peak_o        out  NBITS    window max |sample|
//     sat_cnt_o     out  SATBITS  window count of saturated samples
//     above_o       out  pwr_o > threshold latched for that window
//     valid_o       out  one-cycle strobe; the other outputs change only with it
//   Latency: the last word of a window is sampled on edge k, valid_o rises
//   on edge k+3 (four clocks after that word was presented).
// ---------------------------------------------------------------------------
module biquad_power_monitor
  import bq_mon_pkg::*;
#(
  parameter int ACCBITS = acc_bits(NSAMP, NBITS, WINBITS),
  parameter int SATBITS = sat_bits(NSAMP, WINBITS)
)(
  input  logic                     aclk,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [WINBITS-1:0]       window_len_i,
  input  logic [ACCBITS-1:0]       thresh_i,
  input  logic [NSAMP*NBITS-1:0]   dat_i,
  output logic [ACCBITS-1:0]       pwr_o,
  output logic [NBITS-1:0]         peak_o,
  output logic [SATBITS-1:0]       sat_cnt_o,
  output logic                     above_o,
  output logic                     valid_o
);

  mon_state_e state_q, state_d;

  logic               in_win;
  logic               win_start;
  logic [WINBITS-1:0] len_eff;
  logic [ACCBITS-1:0] thr_eff;
  logic [WINBITS-1:0] cnt_q, cnt_d;
  logic [WINBITS-1:0] len_q;
  logic [ACCBITS-1:0] thr_q;
  word_tag_t          tag_in;

  logic [NSAMP*NBITS-1:0] s1_dat;
  word_tag_t              s1_tag, s2_tag, s3_tag;
  logic [ACCBITS-1:0]     s1_thr, s2_thr, s3_thr;

  logic [SUMBITS-1:0] s3_sum;
  logic [NBITS-1:0]   s3_peak;
  logic [PCBITS-1:0]  s3_sat;

  logic [ACCBITS-1:0] acc_q;
  logic [NBITS-1:0]   peak_acc_q;
  logic [SATBITS-1:0] sat_acc_q;
  logic [ACCBITS-1:0] pwr_tot;
  logic [NBITS-1:0]   peak_tot;
  logic [SATBITS-1:0] sat_tot;

  // State register.
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. The IDLE cycle that sees enable_i only arms the monitor;
  // the window begins on the following (first RUN) cycle. Any RUN cycle
  // with enable_i low drops back to IDLE and contributes nothing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_i)  state_d = ST_RUN;
      ST_RUN:  if (!enable_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Window bookkeeping at the input. On a start cycle the live window_len_i
  // and thresh_i are used directly (they are being latched that same edge),
  // so an N=0 window can close on its own start cycle.
  always_comb begin
    in_win    = (state_q == ST_RUN) && enable_i;
    win_start = in_win && (cnt_q == '0);
    len_eff   = win_start ? window_len_i : len_q;
    thr_eff   = win_start ? thresh_i : thr_q;
    tag_in    = '{valid: in_win, first: win_start, last: in_win && (cnt_q == len_eff)};
    cnt_d     = (!in_win || tag_in.last) ? '0 : cnt_q + WINBITS'(1);
  end

  // Window counter and the per-window latched length and threshold. Leaving
  // RUN clears the counter so the next RUN cycle is always a window start.
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      len_q <= '0;
      thr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (win_start) begin
        len_q <= window_len_i;
        thr_q <= thresh_i;
      end
    end
  end

  // Input register plus the tag/threshold delay line that keeps pace with
  // the two stages inside sumsq8. The threshold rides with every word so that
  // back-to-back short windows each compare against their own latched value.
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      s1_dat <= '0;
      s1_tag <= '0;
      s2_tag <= '0;
      s3_tag <= '0;
      s1_thr <= '0;
      s2_thr <= '0;
      s3_thr <= '0;
    end else begin
      s1_dat <= dat_i;
      s1_tag <= tag_in;
      s2_tag <= s1_tag;
      s3_tag <= s2_tag;
      s1_thr <= thr_eff;
      s2_thr <= s1_thr;
      s3_thr <= s2_thr;
    end
  end

  sumsq8 u_sumsq8 (
    .clk     (aclk),
    .rst     (rst_i),
    .dat     (s1_dat),
    .sum_sq  (s3_sum),
    .peak    (s3_peak),
    .sat_cnt (s3_sat)
  );

  // Running totals including the current word. A first word restarts all
  // three totals, which is also what flushes any partial aborted window.
  always_comb begin
    pwr_tot  = ACCBITS'(s3_sum);
    peak_tot = s3_peak;
    sat_tot  = SATBITS'(s3_sat);
    if (!s3_tag.first) begin
      pwr_tot = acc_q + ACCBITS'(s3_sum);
      sat_tot = sat_acc_q + SATBITS'(s3_sat);
      if (peak_acc_q > s3_peak) begin
        peak_tot = peak_acc_q;
      end
    end
  end

  // Accumulators and output register. Only in-window words move the
  // accumulators; only a last word updates the outputs and fires valid_o,
  // so the outputs hold steady between strobes and aborted windows are silent.
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      acc_q      <= '0;
      peak_acc_q <= '0;
      sat_acc_q  <= '0;
      pwr_o      <= '0;
      peak_o     <= '0;
      sat_cnt_o  <= '0;
      above_o    <= 1'b0;
      valid_o    <= 1'b0;
    end else begin
      valid_o <= s3_tag.valid && s3_tag.last;
      if (s3_tag.valid) begin
        acc_q      <= pwr_tot;
        peak_acc_q <= peak_tot;
        sat_acc_q  <= sat_tot;
      end
      if (s3_tag.valid && s3_tag.last) begin
        pwr_o     <= pwr_tot;
        peak_o    <= peak_tot;
        sat_cnt_o <= sat_tot;
        above_o   <= (pwr_tot > s3_thr);
      end
    end
  end

endmodule
